// File: rtl/heap_pq.sv
// heap_pq: max/min binary-heap priority queue with bulk load, command port and RAM write-out
module heap_pq #(
  parameter int DW       = 8,
  parameter int DEPTH    = 255,
  parameter int MIN_HEAP = 0,
  parameter int AW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic [DW-1:0] data,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  input  logic [AW-1:0] index,
  input  logic [DW-1:0] value,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] count,
  output logic [DW-1:0] top,
  output logic          RAM_valid,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_D,
  output logic          done
);
  typedef enum logic [3:0] {LOAD, IDLE, FETCH, BUILD, SIFT_DOWN, EXTRACT, SIFT_UP, WRITE, DONE} state_t;
  localparam logic [AW-1:0] ONE  = 1;
  localparam logic [AW-1:0] FULL = AW'(DEPTH);
  state_t state_q, state_d;
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] count_q, count_d, i_q, i_d, b_q, b_d, k_q, k_d, idx_q;
  logic [2:0] cmd_q;
  logic [DW-1:0] val_q;
  logic bld_q, bld_d;
  logic wa_en, wb_en;
  logic [AW-1:0] wa_a, wb_a;
  logic [DW-1:0] wa_d, wb_d;
  logic err_q, err_d, done_q, done_d, rv_q, rv_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [DW-1:0] rd_q, rd_d, top_q, top_d;
  logic [AW:0] l, r;
  logic [AW-1:0] m1, m, p, u, cnt1;
  logic [DW-1:0] old;
  function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (MIN_HEAP != 0) ? (a < b) : (a > b);
  endfunction
  assign l = {i_q, 1'b0};
  assign r = {i_q, 1'b1};
  assign p = i_q >> 1;
  assign u = idx_q + ONE;
  assign cnt1 = count_q + ONE;
  assign old = mem_q[u];
  // children beyond count are ignored, so truncated addresses never matter
  assign m1 = (l <= {1'b0, count_q} && better(mem_q[l[AW-1:0]], mem_q[i_q])) ? l[AW-1:0] : i_q;
  assign m = (r <= {1'b0, count_q} && better(mem_q[r[AW-1:0]], mem_q[m1])) ? r[AW-1:0] : m1;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    i_d = i_q;
    b_d = b_q;
    k_d = k_q;
    bld_d = bld_q;
    wa_en = 1'b0;
    wa_a = i_q;
    wa_d = mem_q[m];
    wb_en = 1'b0;
    wb_a = m;
    wb_d = mem_q[i_q];
    err_d = 1'b0;
    done_d = 1'b0;
    rv_d = 1'b0;
    ra_d = '0;
    rd_d = '0;
    case (state_q)
      LOAD:
        if (!data_valid) state_d = IDLE;
        else if (count_q == FULL) err_d = 1'b1;
        else begin
          wa_en = 1'b1;
          wa_a = cnt1;
          wa_d = data;
          count_d = cnt1;
        end
      IDLE: state_d = cmd_valid ? FETCH : IDLE;
      FETCH: begin
        state_d = IDLE;
        case (cmd_q)
          3'd0: begin
            b_d = count_q >> 1;
            bld_d = 1'b1;
            state_d = BUILD;
          end
          3'd1:
            if (count_q == '0) err_d = 1'b1;
            else state_d = EXTRACT;
          3'd2:
            if (idx_q >= count_q) err_d = 1'b1;
            else begin
              wa_en = 1'b1;
              wa_a = u;
              wa_d = val_q;
              i_d = u;
              state_d = better(val_q, old) ? SIFT_UP : better(old, val_q) ? SIFT_DOWN : IDLE;
            end
          3'd3:
            if (count_q == FULL) err_d = 1'b1;
            else begin
              count_d = cnt1;
              wa_en = 1'b1;
              wa_a = cnt1;
              wa_d = val_q;
              i_d = cnt1;
              state_d = SIFT_UP;
            end
          3'd4:
            if (count_q == '0) begin
              done_d = 1'b1;
              state_d = DONE;
            end else begin
              rv_d = 1'b1;
              rd_d = mem_q[ONE];
              k_d = ONE;
              state_d = WRITE;
            end
          3'd5: count_d = '0;
          default: err_d = 1'b1;
        endcase
      end
      BUILD:
        if (b_q == '0) begin
          bld_d = 1'b0;
          state_d = IDLE;
        end else begin
          i_d = b_q;
          b_d = b_q - ONE;
          state_d = SIFT_DOWN;
        end
      SIFT_DOWN:
        if (m != i_q) begin
          wa_en = 1'b1;
          wb_en = 1'b1;
          i_d = m;
        end else state_d = bld_q ? BUILD : IDLE;
      EXTRACT: begin
        wa_en = 1'b1;
        wa_a = ONE;
        wa_d = mem_q[count_q];
        count_d = count_q - ONE;
        i_d = ONE;
        state_d = SIFT_DOWN;
      end
      SIFT_UP:
        if (i_q > ONE && better(mem_q[i_q], mem_q[p])) begin
          wa_en = 1'b1;
          wa_d = mem_q[p];
          wb_en = 1'b1;
          wb_a = p;
          i_d = p;
        end else state_d = IDLE;
      WRITE:
        if (k_q == count_q) begin
          done_d = 1'b1;
          state_d = DONE;
        end else begin
          rv_d = 1'b1;
          ra_d = k_q;
          rd_d = mem_q[k_q + ONE];
          k_d = k_q + ONE;
        end
      DONE: state_d = IDLE;
      default: state_d = LOAD;
    endcase
    // root as it will look after this cycle's writes
    top_d = (count_d == '0) ? '0 : (wa_en && wa_a == ONE) ? wa_d : (wb_en && wb_a == ONE) ? wb_d : mem_q[ONE];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LOAD;
      count_q <= '0;
      i_q <= '0;
      b_q <= '0;
      k_q <= '0;
      bld_q <= 1'b0;
      cmd_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      rv_q <= 1'b0;
      ra_q <= '0;
      rd_q <= '0;
      top_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      i_q <= i_d;
      b_q <= b_d;
      k_q <= k_d;
      bld_q <= bld_d;
      err_q <= err_d;
      done_q <= done_d;
      rv_q <= rv_d;
      ra_q <= ra_d;
      rd_q <= rd_d;
      top_q <= top_d;
      if (state_q == IDLE && cmd_valid) begin
        cmd_q <= cmd;
        idx_q <= index;
        val_q <= value;
      end
    end
  always_ff @(posedge clk) begin
    if (wa_en) mem_q[wa_a] <= wa_d;
    if (wb_en) mem_q[wb_a] <= wb_d;
  end
  assign busy = state_q != IDLE;
  assign err = err_q;
  assign count = count_q;
  assign top = top_q;
  assign RAM_valid = rv_q;
  assign RAM_A = ra_q;
  assign RAM_D = rd_q;
  assign done = done_q;
endmodule
